// File: rtl/fsm_mon_pkg.sv
// Shared types and helpers for the detector event monitor.
// Holds the blank-glyph constant, the BCD digit type and the BCD increment helper.
package fsm_mon_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] STATE_MAX = 4'd8;

  typedef logic [3:0] bcd_t;

  // Returns {carry, digit}; any digit at or above 9 rolls over to 0 with carry.
  function automatic logic [4:0] bcd_inc(input bcd_t d);
    if (d >= 4'd9) return {1'b1, 4'd0};
    return {1'b0, d + 4'd1};
  endfunction

endpackage

// File: rtl/fsm_event_monitor_seg7_dec.sv
// Hex-to-7-segment decoder, active-low {dp,g..a}, decimal point always off.
// Values 10-15 render blank.
module seg7_dec
  import fsm_mon_pkg::*;
(
  input  logic [3:0] value,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (value)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/fsm_event_monitor.sv
// Detection counter (2-digit BCD), longest z-high run tracker and 7-segment drive.
// Optional state digit on hex2 enabled by macro FSM_MON_STATE_HEX_EN.
module fsm_event_monitor
  import fsm_mon_pkg::*;
#(
  parameter bit SATURATE = 1'b0,
  parameter int RUN_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             z,
  input  logic [3:0]       state_led,
  input  logic             clear,
  output logic [7:0]       cnt_bcd,
  output logic [RUN_W-1:0] max_run,
  output logic             event_p,
  output logic [7:0]       hex0,
  output logic [7:0]       hex1,
  output logic [7:0]       hex2
);

  localparam logic [RUN_W-1:0] RUN_MAX = '1;

  logic             z_d;
  logic             rise;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_next;
  logic [RUN_W-1:0] max_next;
  logic [7:0]       cnt_next;
  logic [4:0]       ones_inc;
  logic [4:0]       tens_inc;

  assign rise     = z & ~z_d;
  assign ones_inc = bcd_inc(cnt_bcd[3:0]);
  assign tens_inc = bcd_inc(cnt_bcd[7:4]);

  always_comb begin
    cnt_next = cnt_bcd;
    if (rise) begin
      if (cnt_bcd == 8'h99)
        cnt_next = SATURATE ? 8'h99 : 8'h00;
      else
        cnt_next = {(ones_inc[4] ? tens_inc[3:0] : cnt_bcd[7:4]), ones_inc[3:0]};
    end
  end

  // A rise always starts a fresh run of length 1; the counter sticks at all-ones.
  always_comb begin
    run_next = '0;
    if (rise)
      run_next = RUN_W'(1);
    else if (z)
      run_next = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + RUN_W'(1);
  end

  assign max_next = (run_next > max_run) ? run_next : max_run;

  // z_d keeps sampling during clear so a rise in the clear cycle is lost, not deferred.
  always_ff @(posedge clk) begin
    if (rst) begin
      z_d     <= 1'b0;
      cnt_bcd <= 8'h00;
      run_cnt <= '0;
      max_run <= '0;
      event_p <= 1'b0;
    end else begin
      z_d <= z;
      if (clear) begin
        cnt_bcd <= 8'h00;
        run_cnt <= '0;
        max_run <= '0;
        event_p <= 1'b0;
      end else begin
        cnt_bcd <= cnt_next;
        run_cnt <= run_next;
        max_run <= max_next;
        event_p <= rise;
      end
    end
  end

  seg7_dec u_dec_ones (.value(cnt_bcd[3:0]), .seg(hex0));
  seg7_dec u_dec_tens (.value(cnt_bcd[7:4]), .seg(hex1));

`ifdef FSM_MON_STATE_HEX_EN
  logic [3:0] state_q;

  // Out-of-range states are stored as 4'hF so the decoder blanks them.
  always_ff @(posedge clk) begin
    if (rst)
      state_q <= 4'hF;
    else
      state_q <= (state_led > STATE_MAX) ? 4'hF : state_led;
  end

  seg7_dec u_dec_state (.value(state_q), .seg(hex2));
`else
  logic unused_state;
  assign unused_state = ^state_led;
  assign hex2 = SEG_BLANK;
`endif

endmodule

// File: tb/tb_fsm_event_monitor.sv
// Directed self-checking bench for fsm_event_monitor; runs a wrapping and a
// saturating instance side by side on the same stimulus.
module tb_fsm_event_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       z;
  logic [3:0] state_led;
  logic       clear;

  logic [7:0] cnt_w, cnt_s;
  logic [3:0] max_w, max_s;
  logic       ev_w, ev_s;
  logic [7:0] hex0_w, hex1_w, hex2_w;
  logic [7:0] hex0_s, hex1_s, hex2_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fsm_event_monitor #(.SATURATE(1'b0), .RUN_W(4)) dut_wrap (
    .clk(clk), .rst(rst), .z(z), .state_led(state_led), .clear(clear),
    .cnt_bcd(cnt_w), .max_run(max_w), .event_p(ev_w),
    .hex0(hex0_w), .hex1(hex1_w), .hex2(hex2_w)
  );

  fsm_event_monitor #(.SATURATE(1'b1), .RUN_W(4)) dut_sat (
    .clk(clk), .rst(rst), .z(z), .state_led(state_led), .clear(clear),
    .cnt_bcd(cnt_s), .max_run(max_s), .event_p(ev_s),
    .hex0(hex0_s), .hex1(hex1_s), .hex2(hex2_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; z = 1'b0; clear = 1'b0; state_led = 4'd0;
    tick(); tick();
    check("rst_cnt", cnt_w, 8'h00);
    check("rst_max", {4'h0, max_w}, 8'h00);
    check("rst_ev", {7'h0, ev_w}, 8'h00);
    check("rst_hex0", hex0_w, 8'hC0);
    check("rst_hex1", hex1_w, 8'hC0);
    check("rst_hex2", hex2_w, 8'hFF);
    rst = 1'b0;
    tick();

    // three 2-cycle pulses
    for (int i = 1; i <= 3; i++) begin
      z = 1'b1;
      tick();
      check("pulse_ev_hi", {7'h0, ev_w}, 8'h01);
      check("pulse_cnt", cnt_w, 8'(i));
      tick();
      check("pulse_ev_lo", {7'h0, ev_w}, 8'h00);
      z = 1'b0;
      tick(); tick();
    end
    check("pulse_cnt3", cnt_w, 8'h03);
    check("pulse_max2", {4'h0, max_w}, 8'h02);
    check("pulse_hex0", hex0_w, 8'hB0);
    check("pulse_hex1", hex1_w, 8'hC0);

    // wrap / saturate
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_cnt", cnt_w, 8'h00);
    check("clr_max", {4'h0, max_w}, 8'h00);
    for (int i = 0; i < 99; i++) begin
      z = 1'b1; tick();
      z = 1'b0; tick();
    end
    check("wrap_99", cnt_w, 8'h99);
    check("sat_99", cnt_s, 8'h99);
    check("hex0_9", hex0_w, 8'h90);
    check("hex1_9", hex1_w, 8'h90);
    z = 1'b1;
    tick();
    check("wrap_00", cnt_w, 8'h00);
    check("wrap_ev", {7'h0, ev_w}, 8'h01);
    check("sat_hold", cnt_s, 8'h99);
    check("sat_ev", {7'h0, ev_s}, 8'h01);
    z = 1'b0;
    tick();

    // long run saturates the run counter, counts one event
    z = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("long_max_w", {4'h0, max_w}, 8'h0F);
    check("long_max_s", {4'h0, max_s}, 8'h0F);
    check("long_cnt_w", cnt_w, 8'h01);
    check("long_cnt_s", cnt_s, 8'h99);
    check("long_hex0", hex0_w, 8'hF9);
    z = 1'b0;
    tick();

    // clear coincident with a rise drops the event
    clear = 1'b1; z = 1'b1;
    tick();
    check("clrrise_cnt", cnt_w, 8'h00);
    check("clrrise_ev", {7'h0, ev_w}, 8'h00);
    check("clrrise_max", {4'h0, max_w}, 8'h00);
    clear = 1'b0;
    tick();
    check("clr_nodefer", cnt_w, 8'h00);
    check("clr_nodefer_ev", {7'h0, ev_w}, 8'h00);
    z = 1'b0; tick();
    z = 1'b1; tick();
    check("next_rise", cnt_w, 8'h01);
    check("next_rise_ev", {7'h0, ev_w}, 8'h01);

    // reset with z held high: first cycle after release counts
    rst = 1'b1;
    tick(); tick();
    check("midrst_cnt", cnt_w, 8'h00);
    rst = 1'b0;
    tick();
    check("postrst_cnt", cnt_w, 8'h01);
    check("postrst_ev", {7'h0, ev_w}, 8'h01);
    check("postrst_sat", cnt_s, 8'h01);
    z = 1'b0;
    tick();

    // state digit
`ifdef FSM_MON_STATE_HEX_EN
    state_led = 4'd5; tick();
    check("state5", hex2_w, 8'h92);
    state_led = 4'd12; tick();
    check("state12", hex2_w, 8'hFF);
    state_led = 4'd8; tick();
    check("state8", hex2_w, 8'h80);
    state_led = 4'd9; tick();
    check("state9", hex2_w, 8'hFF);
`else
    state_led = 4'd5; tick();
    check("state5_off", hex2_w, 8'hFF);
    state_led = 4'd8; tick();
    check("state8_off", hex2_s, 8'hFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
